// File: rtl/pal_pkg.sv
// Shared definitions for the PAL configuration front-end: frame constants,
// loader state encoding and the chain-length helper.
package pal_pkg;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY        = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CRC  = 2'd2
  } pal_state_e;

  // Chain length of a PAL with N inputs, P product terms and M outputs.
  function automatic int pal_cfg_bits(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_crc8_serial.sv
// Bit-serial CRC-8 (no reflection, no final XOR), MSB-first input.
module pal_crc8_serial
  import pal_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[7] ^ bit_i;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/pal_cfg_loader.sv
// Framed, CRC-checked configuration loader that serialises the payload into
// the PAL shift chain and enables the PAL only after a clean image.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int         CFG_BITS = pal_cfg_bits(8, 7, 32),
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_bit,
  output logic       cfg_shift,
  output logic       cfg_apply,
  output logic       busy,
  output logic       crc_err,
  output pal_state_e dbg_state
);

  // Stream handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready is a function of loader state only and never looks at in_valid.

  localparam int NBYTES = CFG_BITS / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  pal_state_e     state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     sh_q, sh_d;
  logic [3:0]     sh_cnt_q, sh_cnt_d;
  logic           apply_q, apply_d;
  logic           crc_err_q, crc_err_d;

  logic           accept;
  logic           crc_clr;
  logic [7:0]     crc_val;

  assign in_ready  = (state_q inside {ST_IDLE, ST_LOAD, ST_CRC}) && (sh_cnt_q == 4'd0);
  assign accept    = in_valid && in_ready;
  assign cfg_shift = (sh_cnt_q != 4'd0);
  assign cfg_bit   = cfg_shift ? sh_q[7] : 1'b0;
  assign cfg_apply = apply_q;
  assign crc_err   = crc_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    apply_d    = apply_q;
    crc_err_d  = crc_err_q;
    crc_clr    = 1'b0;

    if (cfg_shift) begin
      sh_d     = {sh_q[6:0], 1'b0};
      sh_cnt_d = sh_cnt_q - 4'd1;
    end

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          // Only a header starts a frame; anything else is dropped silently.
          if (in_data == HDR_BYTE) begin
            state_d    = ST_LOAD;
            byte_cnt_d = '0;
            apply_d    = 1'b0;
            crc_err_d  = 1'b0;
            crc_clr    = 1'b1;
          end
        end
        ST_LOAD: begin
          sh_d       = in_data;
          sh_cnt_d   = 4'd8;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          // Accepted only once the last payload bit has entered the CRC.
          state_d = ST_IDLE;
          if (in_data == crc_val) begin
            apply_d   = 1'b1;
            crc_err_d = 1'b0;
          end else begin
            apply_d   = 1'b0;
            crc_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      sh_q       <= 8'h00;
      sh_cnt_q   <= 4'd0;
      apply_q    <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      apply_q    <= apply_d;
      crc_err_q  <= crc_err_d;
    end
  end

  pal_crc8_serial u_crc (
    .clk   (clk),
    .res_n (res_n),
    .clr_i (crc_clr),
    .en_i  (cfg_shift),
    .bit_i (cfg_bit),
    .crc_o (crc_val)
  );

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: a 16-bit instance for frame/CRC/stall
// cases and a default-size instance for reload and mid-frame reset.
module tb_pal_cfg_loader;
  import pal_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [7:0] in_data = 8'h00;
  logic       v16 = 1'b0, v736 = 1'b0;
  logic       r16, b16, s16, a16, y16, e16;
  logic       r736, b736, s736, a736, y736, e736;
  pal_state_e st16, st736;
  bit         sel = 1'b0;      // 0: 16-bit instance, 1: 736-bit instance
  bit         cur_valid = 1'b0;

  pal_cfg_loader #(.CFG_BITS(16)) dut16 (
    .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(v16),
    .in_ready(r16), .cfg_bit(b16), .cfg_shift(s16), .cfg_apply(a16),
    .busy(y16), .crc_err(e16), .dbg_state(st16)
  );

  pal_cfg_loader dut736 (
    .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(v736),
    .in_ready(r736), .cfg_bit(b736), .cfg_shift(s736), .cfg_apply(a736),
    .busy(y736), .crc_err(e736), .dbg_state(st736)
  );

  logic o_ready, o_bit, o_shift, o_apply, o_busy, o_err;
  assign o_ready = sel ? r736 : r16;
  assign o_bit   = sel ? b736 : b16;
  assign o_shift = sel ? s736 : s16;
  assign o_apply = sel ? a736 : a16;
  assign o_busy  = sel ? y736 : y16;
  assign o_err   = sel ? e736 : e16;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_n) begin
      if (o_shift) begin
        shift_cnt++;
        if (exp_q.size() == 0) check("unexpected_shift", 32'd1, 32'd0);
        else check("cfg_bit", {31'd0, o_bit}, {31'd0, exp_q.pop_front()});
      end else begin
        check("cfg_bit_idle", {31'd0, o_bit}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_valid(input bit v);
    cur_valid = v;
    v16  = sel ? 1'b0 : v;
    v736 = sel ? v : 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b, input bit payload, input bit stall, output int waits);
    int n = 0;
    bit done = 1'b0;
    waits = 0;
    in_data = b;
    while (!done) begin
      set_valid(!(stall && ($urandom_range(0, 1) == 1)));
      if (cur_valid && o_ready) begin
        if (payload) for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        done = 1'b1;
      end else begin
        if (!o_ready) waits++;
        n++;
        if (n > 300) begin
          check("send_timeout", 32'd1, 32'd0);
          set_valid(1'b0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    check({tag, "_bit"},   {31'd0, o_bit},   32'd0);
    check({tag, "_shift"}, {31'd0, o_shift}, 32'd0);
    check({tag, "_apply"}, {31'd0, o_apply}, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
    check({tag, "_err"},   {31'd0, o_err},   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int sc0;

    // Reset values
    repeat (2) @(negedge clk);
    check_idle_outputs("rst16");
    check("rst16_state", {30'd0, st16}, {30'd0, ST_IDLE});
    res_n = 1'b1;
    @(negedge clk);

    // Non-header byte in IDLE is ignored
    send(8'h3C, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);
    check("junk_busy", {31'd0, o_busy}, 32'd0);
    check("junk_noshift", shift_cnt, 32'd0);

    // Good frame, valid held high
    send(8'hA5, 1'b0, 1'b0, w);
    check("hdr_busy", {31'd0, o_busy}, 32'd1);
    check("hdr_apply", {31'd0, o_apply}, 32'd0);
    send(8'h01, 1'b1, 1'b0, w);
    check("gap_first", w, 32'd0);
    send(8'h02, 1'b1, 1'b0, w);
    check("gap_b1", w, 32'd8);
    send(8'h1B, 1'b0, 1'b0, w);
    check("gap_crc", w, 32'd8);
    check("good_apply", {31'd0, o_apply}, 32'd1);
    check("good_err", {31'd0, o_err}, 32'd0);
    check("good_busy", {31'd0, o_busy}, 32'd0);

    // Bad CRC
    sc0 = shift_cnt;
    send(8'hA5, 1'b0, 1'b0, w);
    check("bad_hdr_apply", {31'd0, o_apply}, 32'd0);
    send(8'h01, 1'b1, 1'b0, w);
    send(8'h02, 1'b1, 1'b0, w);
    send(8'h1A, 1'b0, 1'b0, w);
    check("bad_shifts", shift_cnt - sc0, 32'd16);
    check("bad_apply", {31'd0, o_apply}, 32'd0);
    check("bad_err", {31'd0, o_err}, 32'd1);

    // Back-to-back good frame clears crc_err at its header
    send(8'hA5, 1'b0, 1'b0, w);
    check("b2b_hdr_gap", w, 32'd0);
    check("b2b_err_clr", {31'd0, o_err}, 32'd0);
    send(8'h01, 1'b1, 1'b0, w);
    send(8'h02, 1'b1, 1'b0, w);
    send(8'h1B, 1'b0, 1'b0, w);
    check("b2b_apply", {31'd0, o_apply}, 32'd1);
    check("b2b_err", {31'd0, o_err}, 32'd0);

    // Stalled source
    repeat (3) @(negedge clk);
    send(8'hA5, 1'b0, 1'b1, w);
    send(8'h01, 1'b1, 1'b1, w);
    send(8'h02, 1'b1, 1'b1, w);
    send(8'h1B, 1'b0, 1'b1, w);
    check("stall_apply", {31'd0, o_apply}, 32'd1);
    check("stall_err", {31'd0, o_err}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset mid-frame on the default-size instance
    sel = 1'b1;
    set_valid(1'b0);
    @(negedge clk);
    send(8'hA5, 1'b0, 1'b0, w);
    for (int i = 1; i <= 3; i++) send(8'(i), 1'b1, 1'b0, w);
    #2 res_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_state", {30'd0, st736}, {30'd0, ST_IDLE});
    exp_q.delete();
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check("midrst_apply_after", {31'd0, o_apply}, 32'd0);

    // Full all-zero frame
    send(8'hA5, 1'b0, 1'b0, w);
    for (int i = 0; i < 92; i++) send(8'h00, 1'b1, 1'b0, w);
    check("zero_apply_pre", {31'd0, o_apply}, 32'd0);
    send(8'h00, 1'b0, 1'b0, w);
    check("zero_apply", {31'd0, o_apply}, 32'd1);
    check("zero_err", {31'd0, o_err}, 32'd0);

    // Reload: header drops apply, then exactly 736 shifts before the CRC byte
    send(8'hA5, 1'b0, 1'b0, w);
    check("reload_apply_drop", {31'd0, o_apply}, 32'd0);
    sc0 = shift_cnt;
    for (int i = 0; i < 92; i++) begin
      send(8'h00, 1'b1, 1'b0, w);
      if (o_apply !== 1'b0) check("reload_apply_load", {31'd0, o_apply}, 32'd0);
    end
    send(8'h00, 1'b0, 1'b0, w);
    check("reload_shifts", shift_cnt - sc0, 32'd736);
    check("reload_apply", {31'd0, o_apply}, 32'd1);
    check("reload_busy", {31'd0, o_busy}, 32'd0);

    repeat (12) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
